dcm_prog_rx: RTL

// Responder end of the DCM_CLKGEN serial programming port (PROGEN/PROGDATA/PROGDONE).

---
 rtl/dcm_prog_rx_if.sv | 24 ++
 rtl/dcm_prog_rx.sv | 108 ++++++++++
 2 files changed

// File: rtl/dcm_prog_rx_if.sv
// DCM_CLKGEN serial programming port bundle: initiator drives PROGEN/PROGDATA,
// responder returns status plus the modelled M/D registers.
interface dcm_prog_rx_if;
  logic       PROGEN;
  logic       PROGDATA;
  logic       PROGDONE;
  logic       DFSLCKD;
  logic [7:0] M_ACT;
  logic [7:0] D_ACT;
  logic [7:0] M_PEND;
  logic [7:0] D_PEND;
  logic       UPDATED;
  logic       FRAME_ERR;

  modport master (
    output PROGEN, PROGDATA,
    input  PROGDONE, DFSLCKD, M_ACT, D_ACT, M_PEND, D_PEND, UPDATED, FRAME_ERR
  );

  modport slave (
    input  PROGEN, PROGDATA,
    output PROGDONE, DFSLCKD, M_ACT, D_ACT, M_PEND, D_PEND, UPDATED, FRAME_ERR
  );
endinterface

// File: rtl/dcm_prog_rx.sv
// Responder for the DCM_CLKGEN programming port: decodes LOAD-D/LOAD-M/GO frames
// and models the relock that applies pending M/D values.
module dcm_prog_rx #(
  parameter int unsigned LOCK_CYCLES = 64,
  parameter logic [7:0]  M_INIT      = 8'd1,
  parameter logic [7:0]  D_INIT      = 8'd1
) (
  input logic          PROGCLK,
  input logic          RST,
  dcm_prog_rx_if.slave io_prog
);

  localparam int unsigned CntW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRx, StRelock} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [9:0]      r_shift;
  logic [3:0]      r_bitcnt;
  logic            r_ign, w_ign_nxt;
  logic [7:0]      r_m_pend, r_d_pend, r_m_act, r_d_act;
  logic            w_decode, w_go, w_load, w_cnt_one;

  assign w_decode  = (r_state == StRx) && !io_prog.PROGEN;
  assign w_go      = w_decode && (r_bitcnt == 4'd1) && !r_shift[0];
  assign w_load    = w_decode && (r_bitcnt == 4'd10) && r_shift[0];
  assign w_cnt_one = (r_cnt == CntW'(1));
  // A run that touches RELOCK is swallowed whole, even past the end of relock.
  assign w_ign_nxt = io_prog.PROGEN && (r_ign || (r_state == StRelock));

  always_ff @(posedge PROGCLK) begin
    if (RST) begin
      r_state <= StRelock;
      r_cnt   <= CntW'(LOCK_CYCLES);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (io_prog.PROGEN && !r_ign) w_state_nxt = StRx;
      end
      StRx: begin
        if (w_go) begin
          w_state_nxt = StRelock;
          // The GO decode cycle is the first of the LOCK_CYCLES relock cycles.
          w_cnt_nxt   = CntW'(LOCK_CYCLES - 1);
        end else if (!io_prog.PROGEN) begin
          w_state_nxt = StIdle;
        end
      end
      StRelock: begin
        w_cnt_nxt = r_cnt - CntW'(1);
        if (w_cnt_one) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StRelock;
    endcase
  end

  always_comb begin
    io_prog.PROGDONE  = (r_state != StRelock);
    io_prog.DFSLCKD   = (r_state != StRelock);
    io_prog.UPDATED   = (r_state == StRelock) && w_cnt_one;
    io_prog.FRAME_ERR = (w_decode && !w_go && !w_load) || (r_ign && !io_prog.PROGEN);
  end

  always_ff @(posedge PROGCLK) begin
    if (RST) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_ign    <= 1'b0;
      r_m_pend <= M_INIT;
      r_d_pend <= D_INIT;
      r_m_act  <= M_INIT;
      r_d_act  <= D_INIT;
    end else begin
      r_ign <= w_ign_nxt;
      if (r_state == StIdle && io_prog.PROGEN && !r_ign) begin
        r_shift  <= {9'd0, io_prog.PROGDATA};
        r_bitcnt <= 4'd1;
      end
      if (r_state == StRx && io_prog.PROGEN) begin
        if (r_bitcnt < 4'd10) r_shift[r_bitcnt] <= io_prog.PROGDATA;
        if (r_bitcnt != 4'd15) r_bitcnt <= r_bitcnt + 4'd1;
      end
      if (w_load) begin
        if (r_shift[1]) r_m_pend <= r_shift[9:2];
        else            r_d_pend <= r_shift[9:2];
      end
      if (r_state == StRelock && w_cnt_one) begin
        r_m_act <= r_m_pend;
        r_d_act <= r_d_pend;
      end
    end
  end

  assign io_prog.M_ACT  = r_m_act;
  assign io_prog.D_ACT  = r_d_act;
  assign io_prog.M_PEND = r_m_pend;
  assign io_prog.D_PEND = r_d_pend;

endmodule
